// File: rtl/video_sync_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_decoder_if
//  Description : Raw sync/de input bundle and decoded timing outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_sync_decoder_if #(
    parameter int CORDW = 16
);
    logic             hsync_in;
    logic             vsync_in;
    logic             de_in;
    logic             de_out;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             line_start;
    logic             frame_start;
    logic [CORDW-1:0] h_total;
    logic [CORDW-1:0] h_active;
    logic [CORDW-1:0] v_total;
    logic [CORDW-1:0] v_active;
    logic             locked;
    logic             err;

    modport master (
        output hsync_in, vsync_in, de_in,
        input  de_out, sx, sy, line_start, frame_start,
        input  h_total, h_active, v_total, v_active, locked, err
    );

    modport slave (
        input  hsync_in, vsync_in, de_in,
        output de_out, sx, sy, line_start, frame_start,
        output h_total, h_active, v_total, v_active, locked, err
    );
endinterface
`default_nettype wire

// File: rtl/video_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_decoder
//  Description : Recovers pixel coordinates, measures frame geometry, flags lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_sync_decoder #(
    parameter int CORDW       = 16,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  wire logic           clk_pix,
    input  wire logic           rst,
    video_sync_decoder_if.slave vid
);
    localparam logic [CORDW-1:0] C_MAX  = '1;
    localparam logic [CORDW-1:0] C_ONE  = {{(CORDW-1){1'b0}}, 1'b1};
    localparam logic [3:0]       C_LOCK = 4'(LOCK_FRAMES);

    function automatic logic [CORDW-1:0] f_inc(input logic [CORDW-1:0] v);
        return (v == C_MAX) ? v : v + C_ONE;
    endfunction

    logic r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
    logic r_hedge, r_vedge, r_drise, r_dfall;
    logic r_de_out, r_ls, r_fs, r_vflag, r_fline;
    logic [CORDW-1:0] r_sx, r_sy;
    logic [CORDW-1:0] r_hp, r_ha, r_vl, r_va, r_ht_cur, r_ha_cur, r_ht_first, r_ha_first;
    logic r_ht_fv, r_ha_fv, r_bad;
    logic [CORDW-1:0] r_h_total, r_h_active, r_v_total, r_v_active;
    logic r_snap_valid, r_seen_v, r_locked, r_err;
    logic [3:0] r_mc;

    logic [CORDW-1:0] w_sx_n, w_sy_n;
    logic w_fline_n, w_ls_n, w_fs_n, w_vflag_eff;
    logic w_ht_mis, w_ha_mis, w_sat, w_snap_ok, w_locked_n;
    logic [3:0] w_mc_n;

    // Stage 1 samples normalised inputs; stage 2 keeps the previous sample and the edge flags
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            {r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2} <= '0;
            {r_hedge, r_vedge, r_drise, r_dfall}       <= '0;
        end else begin
            r_hs1   <= (vid.hsync_in == H_POL);
            r_vs1   <= (vid.vsync_in == V_POL);
            r_de1   <= vid.de_in;
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
            r_de2   <= r_de1;
            r_hedge <= r_hs1 & ~r_hs2;
            r_vedge <= r_vs1 & ~r_vs2;
            r_drise <= r_de1 & ~r_de2;
            r_dfall <= ~r_de1 & r_de2;
        end
    end

    always_comb begin
        w_vflag_eff = r_vflag | r_vedge;
        w_sx_n      = r_sx;
        w_sy_n      = r_sy;
        w_fline_n   = r_fline;
        if (r_de2) begin
            if (r_drise) begin
                w_sx_n = '0;
                if (w_vflag_eff) begin
                    w_sy_n    = '0;
                    w_fline_n = 1'b1;
                end else begin
                    w_sy_n    = f_inc(r_sy);
                    w_fline_n = 1'b0;
                end
            end else begin
                w_sx_n = f_inc(r_sx);
            end
        end
        w_ls_n = r_de2 && (w_sx_n == '0);
        w_fs_n = w_ls_n && (w_sy_n == '0) && w_fline_n;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            {r_de_out, r_ls, r_fs, r_vflag, r_fline} <= '0;
            r_sx <= '0;
            r_sy <= '0;
        end else begin
            r_de_out <= r_de2;
            r_sx     <= w_sx_n;
            r_sy     <= w_sy_n;
            r_ls     <= w_ls_n;
            r_fs     <= w_fs_n;
            r_fline  <= w_fline_n;
            r_vflag  <= r_drise ? 1'b0 : w_vflag_eff;
        end
    end

    assign w_ht_mis = r_hedge && r_ht_fv && (r_hp != r_ht_first);
    assign w_ha_mis = r_dfall && r_ha_fv && (r_ha != r_ha_first);
    assign w_sat    = (!r_hedge && (r_hp == C_MAX)) || (r_de2 && !r_drise && (r_ha == C_MAX))
                   || (r_hedge && (r_vl == C_MAX)) || (r_drise && (r_va == C_MAX));

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            {r_hp, r_ha, r_vl, r_va}                    <= '0;
            {r_ht_cur, r_ha_cur, r_ht_first, r_ha_first} <= '0;
            {r_ht_fv, r_ha_fv, r_bad}                   <= '0;
        end else begin
            if (r_hedge) begin
                r_ht_cur <= r_hp;
                r_hp     <= C_ONE;
            end else begin
                r_hp <= f_inc(r_hp);
            end
            if (r_drise)     r_ha <= C_ONE;
            else if (r_de2)  r_ha <= f_inc(r_ha);
            if (r_dfall)     r_ha_cur <= r_ha;
            // A hedge coinciding with vedge opens the new frame rather than closing the old one
            if (r_vedge) begin
                r_vl       <= r_hedge ? C_ONE : '0;
                r_va       <= r_drise ? C_ONE : '0;
                r_ht_fv    <= r_hedge;
                r_ht_first <= r_hp;
                r_ha_fv    <= r_dfall;
                r_ha_first <= r_ha;
                r_bad      <= 1'b0;
            end else begin
                if (r_hedge) r_vl <= f_inc(r_vl);
                if (r_drise) r_va <= f_inc(r_va);
                if (r_hedge && !r_ht_fv) begin
                    r_ht_first <= r_hp;
                    r_ht_fv    <= 1'b1;
                end
                if (r_dfall && !r_ha_fv) begin
                    r_ha_first <= r_ha;
                    r_ha_fv    <= 1'b1;
                end
                if (w_ht_mis || w_ha_mis || w_sat) r_bad <= 1'b1;
            end
        end
    end

    // Published outputs double as the previous snapshot for the match test
    always_comb begin
        w_snap_ok = r_snap_valid && !r_bad
                 && (r_ht_cur == r_h_total) && (r_ha_cur == r_h_active)
                 && (r_vl == r_v_total) && (r_va == r_v_active)
                 && (r_ht_cur != '0) && (r_ha_cur != '0) && (r_vl != '0) && (r_va != '0);
        w_mc_n = r_mc;
        if (r_vedge && r_seen_v) begin
            if (!w_snap_ok)            w_mc_n = 4'd0;
            else if (r_mc != C_LOCK)   w_mc_n = r_mc + 4'd1;
        end
        w_locked_n = (w_mc_n == C_LOCK);
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            {r_h_total, r_h_active, r_v_total, r_v_active} <= '0;
            {r_snap_valid, r_seen_v, r_locked, r_err}      <= '0;
            r_mc <= '0;
        end else begin
            r_mc     <= w_mc_n;
            r_locked <= w_locked_n;
            r_err    <= r_locked && !w_locked_n;
            if (r_vedge) begin
                if (!r_seen_v) begin
                    r_seen_v <= 1'b1;
                end else begin
                    r_h_total    <= r_ht_cur;
                    r_h_active   <= r_ha_cur;
                    r_v_total    <= r_vl;
                    r_v_active   <= r_va;
                    r_snap_valid <= 1'b1;
                end
            end
        end
    end

    assign vid.de_out      = r_de_out;
    assign vid.sx          = r_sx;
    assign vid.sy          = r_sy;
    assign vid.line_start  = r_ls;
    assign vid.frame_start = r_fs;
    assign vid.h_total     = r_h_total;
    assign vid.h_active    = r_h_active;
    assign vid.v_total     = r_v_total;
    assign vid.v_active    = r_v_active;
    assign vid.locked      = r_locked;
    assign vid.err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_video_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_sync_decoder
//  Description : Self-checking bench on a reduced 40x20 (32x15 active) raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_sync_decoder;
    localparam int HT = 40, HA = 32, HS0 = 34, HS1 = 38, VT = 20, VA = 15, NF = 16;

    typedef struct packed {
        logic        de;
        logic [15:0] sx;
        logic [15:0] sy;
        logic        ls;
        logic        fs;
    } pix_t;

    typedef struct {
        int   kind;        // 0 normal, 1 long line, 2 hsync/vsync coincident, 3 reset mid-frame
        int   ht, ha, vt, va;
        bit   lk;
        int   errs;
        bit   rise;
    } frame_vec_t;

    logic clk_pix = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_pix = ~clk_pix;

    video_sync_decoder_if #(.CORDW(16)) if_a ();
    video_sync_decoder_if #(.CORDW(16)) if_b ();
    video_sync_decoder_if #(.CORDW(8))  if_c ();

    video_sync_decoder #(.CORDW(16), .H_POL(1'b0), .V_POL(1'b0), .LOCK_FRAMES(2))
        u_dut_a (.clk_pix(clk_pix), .rst(rst), .vid(if_a));
    video_sync_decoder #(.CORDW(16), .H_POL(1'b1), .V_POL(1'b1), .LOCK_FRAMES(2))
        u_dut_b (.clk_pix(clk_pix), .rst(rst), .vid(if_b));
    video_sync_decoder #(.CORDW(8), .H_POL(1'b0), .V_POL(1'b0), .LOCK_FRAMES(2))
        u_dut_c (.clk_pix(clk_pix), .rst(rst), .vid(if_c));

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    pix_t q[$];
    frame_vec_t tv[NF];
    bit rst_chk = 1'b0;
    int errs_a = 0, errs_b = 0, errs_c = 0;
    bit pl_a = 1'b0, pl_b = 1'b0, lock_c = 1'b0;
    int rise_a = -1, rise_b = -1;

    // Reference model state (logical sync levels)
    bit m_pde, m_pvs, m_vf, m_fl;
    logic [15:0] m_sx, m_sy;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic bit all_zero(input logic [15:0] sx, sy, ht, ha, vt, va,
                                    input logic de, ls, fs, lk, er);
        return (sx == 0) && (sy == 0) && (ht == 0) && (ha == 0) && (vt == 0) && (va == 0)
            && !de && !ls && !fs && !lk && !er;
    endfunction

    task automatic check_pix(input string nm, input pix_t got, input pix_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL pix_%s cyc=%0d got de=%0b sx=%0d sy=%0d ls=%0b fs=%0b exp de=%0b sx=%0d sy=%0d ls=%0b fs=%0b",
                      nm, cyc, got.de, got.sx, got.sy, got.ls, got.fs, exp.de, exp.sx, exp.sy, exp.ls, exp.fs);
    endtask

    task automatic check_bit(input string nm, input bit ok, input int got, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_pde = 0; m_pvs = 0; m_vf = 0; m_fl = 0; m_sx = 0; m_sy = 0;
    endtask

    function automatic pix_t model_step(input bit vs, input bit de);
        pix_t e;
        bit drise, vedge, eff;
        drise = de && !m_pde;
        vedge = vs && !m_pvs;
        eff   = m_vf || vedge;
        m_pde = de;
        m_pvs = vs;
        if (de) begin
            if (drise) begin
                m_sx = 0;
                if (eff) begin m_sy = 0; m_fl = 1; end
                else begin m_sy = sat16(m_sy); m_fl = 0; end
            end else begin
                m_sx = sat16(m_sx);
            end
        end
        m_vf = drise ? 1'b0 : eff;
        e.de = de;
        e.sx = m_sx;
        e.sy = m_sy;
        e.ls = de && (m_sx == 0);
        e.fs = e.ls && (m_sy == 0) && m_fl;
        return e;
    endfunction

    // One pixel clock on the main stream: observe, compare oldest pending, then drive
    task automatic drive_cycle(input bit hs, input bit vs, input bit de, input bit r);
        pix_t e, ga, gb;
        @(negedge clk_pix);
        cyc++;
        errs_a += int'(if_a.err);
        errs_b += int'(if_b.err);
        if (if_a.locked && !pl_a) rise_a = cyc;
        if (if_b.locked && !pl_b) rise_b = cyc;
        pl_a = if_a.locked;
        pl_b = if_b.locked;
        if (rst_chk) begin
            rst_chk = 1'b0;
            check_bit("rst_zero_A", all_zero(if_a.sx, if_a.sy, if_a.h_total, if_a.h_active, if_a.v_total,
                      if_a.v_active, if_a.de_out, if_a.line_start, if_a.frame_start, if_a.locked, if_a.err),
                      int'(if_a.sx) + int'(if_a.h_total) + int'(if_a.locked), 0);
            check_bit("rst_zero_B", all_zero(if_b.sx, if_b.sy, if_b.h_total, if_b.h_active, if_b.v_total,
                      if_b.v_active, if_b.de_out, if_b.line_start, if_b.frame_start, if_b.locked, if_b.err),
                      int'(if_b.sx) + int'(if_b.h_total) + int'(if_b.locked), 0);
            check_bit("rst_zero_C", all_zero({8'd0, if_c.sx}, {8'd0, if_c.sy}, {8'd0, if_c.h_total},
                      {8'd0, if_c.h_active}, {8'd0, if_c.v_total}, {8'd0, if_c.v_active}, if_c.de_out,
                      if_c.line_start, if_c.frame_start, if_c.locked, if_c.err),
                      int'(if_c.sy) + int'(if_c.h_total), 0);
        end else if (q.size() == 3) begin
            e = q.pop_front();
            ga = '{if_a.de_out, if_a.sx, if_a.sy, if_a.line_start, if_a.frame_start};
            gb = '{if_b.de_out, if_b.sx, if_b.sy, if_b.line_start, if_b.frame_start};
            check_pix("A", ga, e);
            check_pix("B", gb, e);
        end
        if (r) begin
            rst = 1'b1;
            q.delete();
            model_reset();
            rst_chk = 1'b1;
        end else begin
            rst = 1'b0;
            if_a.hsync_in = ~hs; if_a.vsync_in = ~vs; if_a.de_in = de;
            if_b.hsync_in = hs;  if_b.vsync_in = vs;  if_b.de_in = de;
            q.push_back(model_step(vs, de));
        end
    endtask

    task automatic run_frame(input int kind, output int vcyc);
        bit hs, vs, de, pv;
        int len;
        pv = 0;
        vcyc = -1;
        for (int y = 0; y < VT; y++) begin
            len = (kind == 1 && y == 5) ? HT + 1 : HT;
            for (int x = 0; x < len; x++) begin
                de = (y < VA) && (x < HA);
                hs = (x >= HS0) && (x < HS1);
                if (kind == 2) vs = (y == 16 && x >= HS0) || (y == 17) || (y == 18 && x < HS0);
                else           vs = (y == 16) || (y == 17);
                if (kind == 3 && y == 8 && x == HT - 1) drive_cycle(0, 0, 0, 1);
                else                                   drive_cycle(hs, vs, de, 0);
                if (vs && !pv) vcyc = cyc;
                pv = vs;
            end
        end
    endtask

    task automatic check_frame(input string nm, input int f, input logic [15:0] ht, ha, vt, va,
                               input logic lk, input int errs);
        n_chk++;
        if ({ht, ha, vt, va} == {16'(tv[f].ht), 16'(tv[f].ha), 16'(tv[f].vt), 16'(tv[f].va)}) n_pass++;
        else $display("FAIL size_%s frame=%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", nm, f,
                      ht, ha, vt, va, tv[f].ht, tv[f].ha, tv[f].vt, tv[f].va);
        check_bit({"locked_", nm}, lk == tv[f].lk, int'(lk), int'(tv[f].lk));
        check_bit({"errcnt_", nm}, errs == tv[f].errs, errs, tv[f].errs);
    endtask

    task automatic c_cycle(input logic de);
        @(negedge clk_pix);
        errs_c += int'(if_c.err);
        if (if_c.locked) lock_c = 1'b1;
        if_c.de_in = de;
    endtask

    function automatic frame_vec_t fv(input int kind, input bit snap, input bit lk, input int errs, input bit rise);
        frame_vec_t v;
        v.kind = kind;
        v.ht = snap ? HT : 0;
        v.ha = snap ? HA : 0;
        v.vt = snap ? VT : 0;
        v.va = snap ? VA : 0;
        v.lk = lk;
        v.errs = errs;
        v.rise = rise;
        return v;
    endfunction

    initial begin
        int vc;
        tv[0]  = fv(0, 0, 0, 0, 0);
        tv[1]  = fv(0, 1, 0, 0, 0);
        tv[2]  = fv(0, 1, 0, 0, 0);
        tv[3]  = fv(0, 1, 1, 0, 1);
        tv[4]  = fv(0, 1, 1, 0, 0);
        tv[5]  = fv(0, 1, 1, 0, 0);
        tv[6]  = fv(1, 1, 0, 1, 0);
        tv[7]  = fv(0, 1, 0, 0, 0);
        tv[8]  = fv(0, 1, 1, 0, 1);
        tv[9]  = fv(3, 0, 0, 0, 0);
        tv[10] = fv(0, 1, 0, 0, 0);
        tv[11] = fv(0, 1, 0, 0, 0);
        tv[12] = fv(0, 1, 1, 0, 1);
        tv[13] = fv(2, 1, 1, 0, 0);
        tv[14] = fv(2, 1, 1, 0, 0);
        tv[15] = fv(2, 1, 1, 0, 0);

        if_a.hsync_in = 1'b1; if_a.vsync_in = 1'b1; if_a.de_in = 1'b0;
        if_b.hsync_in = 1'b0; if_b.vsync_in = 1'b0; if_b.de_in = 1'b0;
        if_c.hsync_in = 1'b1; if_c.vsync_in = 1'b1; if_c.de_in = 1'b0;
        model_reset();

        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 0, 0, 1);

        for (int f = 0; f < NF; f++) begin
            errs_a = 0;
            errs_b = 0;
            run_frame(tv[f].kind, vc);
            check_frame("A", f, if_a.h_total, if_a.h_active, if_a.v_total, if_a.v_active, if_a.locked, errs_a);
            check_frame("B", f, if_b.h_total, if_b.h_active, if_b.v_total, if_b.v_active, if_b.locked, errs_b);
            if (tv[f].rise) begin
                check_bit("lock_rise_cyc_A", rise_a == vc + 3, rise_a, vc + 3);
                check_bit("lock_rise_cyc_B", rise_b == vc + 3, rise_b, vc + 3);
            end
        end
        repeat (3) drive_cycle(0, 0, 0, 0);

        // de-only stream on the narrow instance: sy must count from 1 and stick at 255
        errs_c = 0;
        lock_c = 1'b0;
        for (int i = 0; i < 100; i++) begin
            c_cycle(1'b1);
            c_cycle(1'b0);
        end
        repeat (3) c_cycle(1'b0);
        check_bit("sat_sy_mid", if_c.sy == 8'd100, int'(if_c.sy), 100);
        check_bit("sat_sx_mid", if_c.sx == 8'd0 && !if_c.de_out, int'(if_c.sx), 0);
        for (int i = 0; i < 250; i++) begin
            c_cycle(1'b1);
            c_cycle(1'b0);
        end
        repeat (3) c_cycle(1'b0);
        check_bit("sat_sy_max", if_c.sy == 8'd255, int'(if_c.sy), 255);
        check_bit("sat_no_lock", !lock_c, int'(lock_c), 0);
        check_bit("sat_no_err", errs_c == 0, errs_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
